// File: rtl/flag_unit.sv
// Condition-flag unit: a one-deep capture stage feeding the architectural Z/N/V register.
// Define FLAG_BYPASS_EN to forward the pending stage flags onto Z/N/V before they commit.
module flag_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       op_class,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovfl,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             flags_pending
);

  localparam logic [1:0] CLS_NONE  = 2'b00;
  localparam logic [1:0] CLS_ARITH = 2'b01;
  localparam logic [1:0] CLS_LOGIC = 2'b10;
  localparam logic [1:0] CLS_RSVD  = 2'b11;

  // Flag vector ordering is {Z, N, V} throughout.
  function automatic logic [2:0] calc_flags(input logic [WIDTH-1:0] res, input logic ovf);
    return {(res == {WIDTH{1'b0}}), res[WIDTH-1], ovf};
  endfunction

  logic       stg_valid_r;
  logic [1:0] stg_class_r;
  logic [2:0] stg_flags_r;
  logic [2:0] arch_flags_r;
  logic       capture_s;
  logic [2:0] merged_s;
  logic [2:0] visible_s;

  // Decide whether the current input produces a flag write.
  always_comb begin
    capture_s = 1'b0;
    case (op_class)
      CLS_ARITH: capture_s = valid;
      CLS_LOGIC: capture_s = valid;
      CLS_NONE:  capture_s = 1'b0;
      CLS_RSVD:  capture_s = 1'b0;
      default:   capture_s = 1'b0;
    endcase
  end

  // Stage flags laid over the architectural flags with per-class masking.
  always_comb begin
    merged_s = arch_flags_r;
    case (stg_class_r)
      CLS_ARITH: merged_s = stg_flags_r;
      CLS_LOGIC: merged_s = {stg_flags_r[2], arch_flags_r[1:0]};
      default:   merged_s = arch_flags_r;
    endcase
  end

  // Capture and commit pipeline; flush outranks stall, reset outranks both.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid_r  <= 1'b0;
      stg_class_r  <= 2'b00;
      stg_flags_r  <= 3'b000;
      arch_flags_r <= 3'b000;
    end else if (flush) begin
      stg_valid_r <= 1'b0;
    end else if (!stall) begin
      if (stg_valid_r) begin
        arch_flags_r <= merged_s;
      end
      stg_valid_r <= capture_s;
      stg_class_r <= op_class;
      stg_flags_r <= calc_flags(alu_result, alu_ovfl);
    end
  end

`ifdef FLAG_BYPASS_EN
  // Forward an uncommitted write so branches see it one cycle early.
  always_comb begin
    if (stg_valid_r) begin
      visible_s = merged_s;
    end else begin
      visible_s = arch_flags_r;
    end
  end
`else
  assign visible_s = arch_flags_r;
`endif

  assign {Z, N, V}     = visible_s;
  assign flags_pending = stg_valid_r;

endmodule

// File: tb/tb_flag_unit.sv
// Randomized scoreboard bench for flag_unit with a queue-based reference model.
// Honors FLAG_BYPASS_EN the same way the design does.
module tb_flag_unit;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       op_class = 2'b00;
  logic [WIDTH-1:0] alu_result = '0;
  logic             alu_ovfl = 1'b0;
  logic             Z, N, V, flags_pending;

  flag_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .valid(valid), .stall(stall), .flush(flush),
    .op_class(op_class), .alu_result(alu_result), .alu_ovfl(alu_ovfl),
    .Z(Z), .N(N), .V(V), .flags_pending(flags_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] cls; logic z; logic n; logic v; } op_t;
  op_t        pend_q[$];
  logic [3:0] exp_q[$];
  logic       az = 1'b0, an = 1'b0, av = 1'b0;
  int         checks = 0;
  int         errors = 0;

  // Apply one cycle of stimulus and predict the outputs visible after the edge.
  task automatic step(input logic r, input logic vl, input logic st, input logic fl,
                      input logic [1:0] cls, input logic [WIDTH-1:0] res, input logic ovf);
    logic [2:0] vis;
    @(negedge clk);
    rst = r; valid = vl; stall = st; flush = fl;
    op_class = cls; alu_result = res; alu_ovfl = ovf;
    if (r) begin
      pend_q.delete();
      az = 1'b0; an = 1'b0; av = 1'b0;
    end else if (fl) begin
      pend_q.delete();
    end else if (!st) begin
      if (pend_q.size() > 0) begin
        op_t o;
        o = pend_q.pop_front();
        az = o.z;
        if (o.cls == 2'b01) begin
          an = o.n; av = o.v;
        end
      end
      if (vl && (cls == 2'b01 || cls == 2'b10))
        pend_q.push_back('{cls, (res == 16'h0000), res[WIDTH-1], ovf});
    end
    vis = {az, an, av};
`ifdef FLAG_BYPASS_EN
    if (pend_q.size() > 0) begin
      vis[2] = pend_q[0].z;
      if (pend_q[0].cls == 2'b01) vis[1:0] = {pend_q[0].n, pend_q[0].v};
    end
`endif
    exp_q.push_back({vis, (pend_q.size() > 0)});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h1234, 1'b0);
  endtask

  // Literal check right after the edge that the preceding step drove.
  task automatic check_now(input string name, input logic [3:0] want);
    @(posedge clk);
    #2;
    checks++;
    if ({Z, N, V, flags_pending} !== want) begin
      errors++;
      $display("FAIL %s: got ZNVP=%b want %b", name, {Z, N, V, flags_pending}, want);
    end
  endtask

  // Monitor: compare every post-edge output against the oldest prediction.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({Z, N, V, flags_pending} !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got ZNVP=%b want %b", $time, {Z, N, V, flags_pending}, e);
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] r;
    // Reset overrides an arith capture of zero
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0000, 1'b1);
    check_now("reset", 4'b0000);

    // Arith then logic, with masking of N/V on the logic commit
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h8000, 1'b1);
    idle();
    check_now("arith_commit", 4'b0110);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 16'h0000, 1'b0);
    idle();
    check_now("logic_commit", 4'b1110);

    // Stall holds a pending zero-result write
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0005, 1'b0);
    idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0000, 1'b0);
`ifdef FLAG_BYPASS_EN
    check_now("bypass_capture", 4'b1001);
`else
    check_now("nobypass_capture", 4'b0001);
`endif
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 16'h7777, 1'b1);
`ifdef FLAG_BYPASS_EN
      check_now("stall_hold", 4'b1001);
`else
      check_now("stall_hold", 4'b0001);
`endif
    end
    idle();
    check_now("stall_release", 4'b1000);

    // Flush together with stall discards a negative result
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'hFFFF, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 16'h0001, 1'b0);
    check_now("flush_stall", 4'b1000);
    idle();
    check_now("flush_after", 4'b1000);

    // Back-to-back arith results
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h0005, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h8001, 1'b0);
    idle();
    check_now("b2b_last", 4'b0100);

    // Reset discards a pending write
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 16'h8000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b0);
    idle();
    check_now("reset_discard", 4'b0000);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 16'h0000;
        1:       r = 16'h8000;
        default: r = WIDTH'($urandom);
      endcase
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)), r, 1'($urandom));
    end
    idle();
    idle();
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
